// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner and next-PC sequencer for the MIPS32 core.
// Selects among sequential, branch, jump and jump-register targets, tolerates
// instruction-memory wait states and core stalls, and keeps a redirect pending
// until the outstanding fetch completes.
// Optional macro BRANCH_DELAY_SLOT_EN: a non-sequential target is taken only
// after the delay-slot instruction (pc_plus4) has been fetched.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        redirect,
    output logic        misaligned_err
);

`ifdef BRANCH_DELAY_SLOT_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DLY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_pend_vld;
    logic        w_pend_vld_nxt;
    logic [31:0] r_pend_tgt;    // pending redirect, or stored target while in the delay slot
    logic [31:0] w_pend_tgt_nxt;
    logic        r_redirect;
    logic        w_redirect_nxt;
    logic        r_mis;
    logic        w_mis_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_sel_tgt;
    logic        w_sel_ns;      // a non-sequential source is requested
    logic        w_sel_mis;     // JR selected with a misaligned register value
    logic        w_done;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign w_done     = imem_ready & ~stall;

    // Priority select of the requested target: JR > J > branch > sequential.
    always_comb begin
        w_sel_tgt = w_pc_plus4;
        w_sel_ns  = 1'b0;
        w_sel_mis = 1'b0;
        if (jump_reg) begin
            w_sel_tgt = {jr_target[31:2], 2'b00};
            w_sel_ns  = 1'b1;
            w_sel_mis = (jr_target[1:0] != 2'b00);
        end else if (jump) begin
            w_sel_tgt = {w_pc_plus4[31:28], jump_index, 2'b00};
            w_sel_ns  = 1'b1;
        end else if (branch_taken) begin
            w_sel_tgt = w_pc_plus4 + w_br_off;
            w_sel_ns  = 1'b1;
        end
    end

    // Next-state, next-PC and pulse generation.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_tgt_nxt = r_pend_tgt;
        w_redirect_nxt = 1'b0;
        w_mis_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!imem_ready) begin
                    // Fetch stalls on memory: remember any redirect until it completes.
                    w_state_nxt = S_WAIT;
                    if (w_sel_ns) begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_tgt_nxt = w_sel_tgt;
                        w_mis_nxt      = w_sel_mis;
                    end
                end else if (!stall) begin
                    w_mis_nxt = w_sel_mis;
                    if (w_sel_ns) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        w_pc_nxt       = w_pc_plus4;
                        w_pend_vld_nxt = 1'b1;
                        w_pend_tgt_nxt = w_sel_tgt;
                        w_state_nxt    = S_DLY;
`else
                        w_pc_nxt       = w_sel_tgt;
                        w_redirect_nxt = 1'b1;
`endif
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
            S_WAIT: begin
                if (w_done) begin
                    w_state_nxt    = S_RUN;
                    w_pend_vld_nxt = 1'b0;
                    if (r_pend_vld) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        w_pc_nxt       = w_pc_plus4;
                        w_pend_vld_nxt = 1'b1;
                        w_state_nxt    = S_DLY;
`else
                        w_pc_nxt       = r_pend_tgt;
                        w_redirect_nxt = 1'b1;
`endif
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
`ifdef BRANCH_DELAY_SLOT_EN
            S_DLY: begin
                if (w_done) begin
                    w_pc_nxt       = r_pend_tgt;
                    w_pend_vld_nxt = 1'b0;
                    w_redirect_nxt = 1'b1;
                    w_state_nxt    = S_RUN;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any pending target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_pend_vld <= 1'b0;
            r_pend_tgt <= 32'h0;
            r_redirect <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_redirect <= w_redirect_nxt;
            r_mis      <= w_mis_nxt;
        end
    end

    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign fetch_valid    = (r_state != S_IDLE);
    assign redirect       = r_redirect;
    assign misaligned_err = r_mis;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors, a transaction-level PC model
// compared every cycle, and literal expectations from hand calculation.
module tb_pc_sequencer;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = 16'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'h0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, redirect, misaligned_err;

    int n_vec = 0;
    int n_err = 0;

    pc_sequencer #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_index(jump_index), .jump_reg(jump_reg),
        .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .redirect(redirect),
        .misaligned_err(misaligned_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_live, m_wait, m_dly, m_pv, m_rd, m_me;
    logic [31:0] m_pt;

    function automatic logic [31:0] want_target(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = cur + 32'd4;
        if (jump_reg)          return jr_target & ~32'd3;
        else if (jump)         return (nxt & 32'hF000_0000) | (32'(jump_index) * 32'd4);
        else if (branch_taken) return nxt + 32'($signed(branch_offset)) * 32'd4;
        return nxt;
    endfunction

    wire ctrl_any = jump_reg | jump | branch_taken;
    wire jr_bad   = jump_reg && (jr_target % 4 != 0);
    wire done     = imem_ready && !stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= RPC; m_live <= 0; m_wait <= 0; m_dly <= 0;
            m_pv <= 0; m_pt <= 0; m_rd <= 0; m_me <= 0;
        end else if (!m_live) begin
            m_live <= 1; m_rd <= 0; m_me <= 0;
        end else begin
            m_rd <= 0; m_me <= 0;
            if (m_dly) begin
                if (done) begin m_pc <= m_pt; m_rd <= 1; m_dly <= 0; m_pv <= 0; end
            end else if (m_wait) begin
                if (done) begin
                    m_wait <= 0; m_pv <= 0;
                    if (m_pv) begin
`ifdef BRANCH_DELAY_SLOT_EN
                        m_pc <= m_pc + 4; m_dly <= 1; m_pv <= 1;
`else
                        m_pc <= m_pt; m_rd <= 1;
`endif
                    end else m_pc <= m_pc + 4;
                end
            end else if (!imem_ready) begin
                m_wait <= 1;
                if (ctrl_any) begin m_pv <= 1; m_pt <= want_target(m_pc); m_me <= jr_bad; end
            end else if (!stall) begin
                m_me <= jr_bad;
                if (ctrl_any) begin
`ifdef BRANCH_DELAY_SLOT_EN
                    m_pc <= m_pc + 4; m_pt <= want_target(m_pc); m_pv <= 1; m_dly <= 1;
`else
                    m_pc <= want_target(m_pc); m_rd <= 1;
`endif
                end else m_pc <= m_pc + 4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_live});
        chk("redirect", {31'b0, redirect}, {31'b0, m_rd});
        chk("misaligned_err", {31'b0, misaligned_err}, {31'b0, m_me});
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic rdy, input logic st, input logic bt, input logic [15:0] bo,
                         input logic j, input logic [25:0] ji, input logic jr, input logic [31:0] jt);
        imem_ready = rdy; stall = st; branch_taken = bt; branch_offset = bo;
        jump = j; jump_index = ji; jump_reg = jr; jr_target = jt;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rdy);
        apply(rdy, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst pc", pc, RPC);
        chk("rst fetch_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst redirect", {31'b0, redirect}, 32'h0);
        rst_n = 1'b1;
        idle(1);
        chk("leave pc", pc, 32'h0040_0000);
        chk("leave fetch_valid", {31'b0, fetch_valid}, 32'h1);
        idle(1); chk("seq1", pc, 32'h0040_0004);
        idle(1); chk("seq2", pc, 32'h0040_0008);
        idle(1); chk("seq3", pc, 32'h0040_000C);
`ifndef BRANCH_DELAY_SLOT_EN
        apply(1, 0, 0, 16'h0, 0, 26'h0, 1, 32'h1000_0010);
        chk("jr pc", pc, 32'h1000_0010);
        apply(1, 0, 0, 16'h0, 1, 26'h000_0040, 0, 32'h0);
        chk("jump pc", pc, 32'h1000_0100);
        chk("jump redirect", {31'b0, redirect}, 32'h1);
        idle(1);
        chk("jump redirect end", {31'b0, redirect}, 32'h0);
        chk("after jump pc", pc, 32'h1000_0104);
        apply(1, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0020);
        apply(1, 0, 1, 16'hFFF8, 0, 26'h0, 0, 32'h0);
        chk("bwd branch", pc, 32'h0000_0004);
        apply(1, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC);
        idle(1);
        chk("wrap", pc, 32'h0000_0000);
        chk("wrap no redirect", {31'b0, redirect}, 32'h0);
        apply(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_2000);
        chk("wait1", pc, 32'h0);
        idle(0); chk("wait2", pc, 32'h0);
        idle(0); chk("wait3", pc, 32'h0);
        idle(1);
        chk("pending pc", pc, 32'h0000_2000);
        chk("pending redirect", {31'b0, redirect}, 32'h1);
        apply(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_5000);
        idle(0); idle(0);
        apply(1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
        chk("wait stall hold", pc, 32'h0000_2000);
        idle(1);
        chk("pending kept", pc, 32'h0000_5000);
        apply(1, 0, 1, 16'h0010, 1, 26'h123_4567, 1, 32'h0000_3006);
        chk("priority pc", pc, 32'h0000_3004);
        chk("misaligned pulse", {31'b0, misaligned_err}, 32'h1);
        chk("priority redirect", {31'b0, redirect}, 32'h1);
        idle(1);
        chk("misaligned end", {31'b0, misaligned_err}, 32'h0);
        apply(1, 1, 0, 16'h0, 1, 26'h000_0100, 0, 32'h0);
        chk("run stall hold", pc, 32'h0000_3008);
        idle(0); idle(1);
        chk("wait no pending", pc, 32'h0000_300C);
        chk("wait no redirect", {31'b0, redirect}, 32'h0);
        apply(0, 0, 0, 16'h0, 1, 26'h000_0100, 0, 32'h0);
        rst_n = 1'b0;
        #2;
        chk("reset mid-wait pc", pc, RPC);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(1); idle(1);
        chk("pending discarded", pc, 32'h0040_0004);
        chk("pending discarded redirect", {31'b0, redirect}, 32'h0);
`else
        apply(1, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_0100);
        chk("dly slot jr", pc, 32'h0040_0010);
        idle(1);
        chk("dly jr target", pc, 32'h0000_0100);
        apply(1, 0, 0, 16'h0, 1, 26'h000_0100, 0, 32'h0);
        chk("dly slot pc", pc, 32'h0000_0104);
        chk("dly slot no redirect", {31'b0, redirect}, 32'h0);
        idle(1);
        chk("dly target", pc, 32'h0000_0400);
        chk("dly redirect", {31'b0, redirect}, 32'h1);
        apply(1, 0, 0, 16'h0, 1, 26'h000_0200, 0, 32'h0);
        chk("dly slot 2", pc, 32'h0000_0404);
        rst_n = 1'b0;
        #2;
        chk("reset in dly", pc, RPC);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(1); idle(1);
        chk("dly target lost", pc, 32'h0040_0004);
        chk("dly lost redirect", {31'b0, redirect}, 32'h0);
`endif
        idle(1);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
